// File: rtl/px_adc_pkg.sv
// Shared constants and types for the three-channel pixel ADC capture block.
package px_adc_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int SAMPLE_BITS = 12;
  localparam int HALF_W      = $clog2(2 * FRAME_BITS);

  typedef logic [HALF_W-1:0] half_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } state_t;

endpackage

// File: rtl/px_adc_capture_if.sv
// Control/data link between the capture sequencer and one serial shifter.
interface px_adc_capture_if;
  import px_adc_pkg::*;

  logic                  clear;
  logic                  sample;
  logic                  din;
  logic [FRAME_BITS-1:0] frame;

  modport master (output clear, output sample, output din, input frame);
  modport slave  (input clear, input sample, input din, output frame);

endinterface

// File: rtl/px_adc_shift.sv
// One 16-bit MSB-first serial shifter; shifts din in on each sample strobe.
module px_adc_shift
  import px_adc_pkg::*;
(
  input logic             clk,
  input logic             reset,
  px_adc_capture_if.slave link
);

  logic [FRAME_BITS-1:0] frame_q;

  // NOTE: clocked state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
    end else if (link.clear) begin
      frame_q <= '0;
    end else if (link.sample) begin
      frame_q <= {frame_q[FRAME_BITS-2:0], link.din};
    end
  end

  assign link.frame = frame_q;

endmodule

// File: rtl/px_adc_capture.sv
// Drives shared CS/SCLK to three serial ADCs, captures one 12-bit sample per
// ADC per start request and strobes the triple into a downstream FIFO.
module px_adc_capture
  import px_adc_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int QUIET_CYC = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_capture,
  input  logic                   px0_adc_din,
  input  logic                   px1_adc_din,
  input  logic                   px2_adc_din,
  output logic                   CS,
  output logic                   SCLK,
  output logic [SAMPLE_BITS-1:0] px0_data,
  output logic [SAMPLE_BITS-1:0] px1_data,
  output logic [SAMPLE_BITS-1:0] px2_data,
  output logic                   wr_en,
  input  logic                   fifo_full,
  output logic                   busy,
  output logic                   conv_complete,
  output logic                   overflow
);

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam half_t       HALF_LAST  = half_t'(2 * FRAME_BITS - 1);
  localparam logic [15:0] QUIET_LAST = 16'(QUIET_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  half_t       half_q, half_d;
  logic [15:0] quiet_q, quiet_d;
  logic        cs_d, sclk_d, wr_d, conv_d, busy_d, ovf_d;
  logic        phase_end, clear, sample, latch;

  px_adc_capture_if link0 ();
  px_adc_capture_if link1 ();
  px_adc_capture_if link2 ();

  assign link0.clear  = clear;
  assign link1.clear  = clear;
  assign link2.clear  = clear;
  assign link0.sample = sample;
  assign link1.sample = sample;
  assign link2.sample = sample;
  assign link0.din    = px0_adc_din;
  assign link1.din    = px1_adc_din;
  assign link2.din    = px2_adc_din;

  px_adc_shift u_shift0 (.clk(clk), .reset(reset), .link(link0));
  px_adc_shift u_shift1 (.clk(clk), .reset(reset), .link(link1));
  px_adc_shift u_shift2 (.clk(clk), .reset(reset), .link(link2));

  // The four leading frame bits are always zero from the ADC and are dropped.
  logic unused_lead;
  assign unused_lead = ^{link0.frame[FRAME_BITS-1:SAMPLE_BITS],
                         link1.frame[FRAME_BITS-1:SAMPLE_BITS],
                         link2.frame[FRAME_BITS-1:SAMPLE_BITS]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      quiet_q <= quiet_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    quiet_d   = quiet_q;
    cs_d      = CS;
    sclk_d    = SCLK;
    busy_d    = busy;
    ovf_d     = overflow;
    wr_d      = 1'b0;
    conv_d    = 1'b0;
    clear     = 1'b0;
    sample    = 1'b0;
    latch     = 1'b0;
    phase_end = (div_q == DIV_LAST);

    unique case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b1;
        if (start_capture) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          clear   = 1'b1;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          div_d   = '0;
          half_d  = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        // Even half-periods are SCLK low; data is taken as SCLK goes high.
        if (phase_end) begin
          div_d = '0;
          if (half_q == HALF_LAST) begin
            state_d = DONE;
            cs_d    = 1'b1;
            sclk_d  = 1'b1;
            conv_d  = 1'b1;
            wr_d    = !fifo_full;
            ovf_d   = overflow | fifo_full;
            latch   = 1'b1;
          end else begin
            half_d = half_q + half_t'(1);
            sclk_d = ~SCLK;
            sample = ~SCLK;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        state_d = QUIET;
        quiet_d = '0;
      end
      QUIET: begin
        if (quiet_q == QUIET_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          quiet_d = quiet_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CS            <= 1'b1;
      SCLK          <= 1'b1;
      wr_en         <= 1'b0;
      conv_complete <= 1'b0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      px0_data      <= '0;
      px1_data      <= '0;
      px2_data      <= '0;
    end else begin
      CS            <= cs_d;
      SCLK          <= sclk_d;
      wr_en         <= wr_d;
      conv_complete <= conv_d;
      busy          <= busy_d;
      overflow      <= ovf_d;
      if (latch) begin
        px0_data <= link0.frame[SAMPLE_BITS-1:0];
        px1_data <= link1.frame[SAMPLE_BITS-1:0];
        px2_data <= link2.frame[SAMPLE_BITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_px_adc_capture.sv
// Directed bench: main DUT (CLK_DIV=2) with ADC model and scoreboard, plus
// CLK_DIV=1 and CLK_DIV=5 instances for timing checks.
`timescale 1ns/1ps
module tb_px_adc_capture;

  typedef struct {
    logic [11:0] p0, p1, p2;
    logic        wr;
    logic        ovf;
    int          start;
  } exp_t;

  localparam int DIVS [3] = '{2, 1, 5};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_capture = 1'b0;
  logic fifo_full = 1'b0;
  logic din0 = 1'b0, din1 = 1'b0, din2 = 1'b0;

  logic        cs_a [3];
  logic        sclk_a [3];
  logic        wr_a [3];
  logic        cc_a [3];
  logic        busy_a [3];
  logic        ovf_a [3];
  logic [11:0] d0_a [3];
  logic [11:0] d1_a [3];
  logic [11:0] d2_a [3];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  int   rise_n [3] = '{0, 0, 0};
  int   rise0 [3] = '{0, 0, 0};
  int   rise1 [3] = '{0, 0, 0};
  int   conv_cyc [3] = '{0, 0, 0};
  logic sclk_prev [3] = '{1'b1, 1'b1, 1'b1};
  int   cs_run = 0;
  int   last_cs_run = 0;
  int   wr_pulses = 0;
  int   exp_wr = 0;
  logic ovf_model = 1'b0;
  exp_t sb [$];

  logic [15:0] word0 = '0, word1 = '0, word2 = '0;
  int          bit_idx = 15;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  px_adc_capture #(.CLK_DIV(2), .QUIET_CYC(4)) dut (
    .clk(clk), .reset(reset), .start_capture(start_capture),
    .px0_adc_din(din0), .px1_adc_din(din1), .px2_adc_din(din2),
    .CS(cs_a[0]), .SCLK(sclk_a[0]),
    .px0_data(d0_a[0]), .px1_data(d1_a[0]), .px2_data(d2_a[0]),
    .wr_en(wr_a[0]), .fifo_full(fifo_full), .busy(busy_a[0]),
    .conv_complete(cc_a[0]), .overflow(ovf_a[0]));

  px_adc_capture #(.CLK_DIV(1), .QUIET_CYC(4)) dut1 (
    .clk(clk), .reset(reset), .start_capture(start_capture),
    .px0_adc_din(1'b1), .px1_adc_din(1'b0), .px2_adc_din(1'b1),
    .CS(cs_a[1]), .SCLK(sclk_a[1]),
    .px0_data(d0_a[1]), .px1_data(d1_a[1]), .px2_data(d2_a[1]),
    .wr_en(wr_a[1]), .fifo_full(fifo_full), .busy(busy_a[1]),
    .conv_complete(cc_a[1]), .overflow(ovf_a[1]));

  px_adc_capture #(.CLK_DIV(5), .QUIET_CYC(4)) dut5 (
    .clk(clk), .reset(reset), .start_capture(start_capture),
    .px0_adc_din(1'b1), .px1_adc_din(1'b0), .px2_adc_din(1'b1),
    .CS(cs_a[2]), .SCLK(sclk_a[2]),
    .px0_data(d0_a[2]), .px1_data(d1_a[2]), .px2_data(d2_a[2]),
    .wr_en(wr_a[2]), .fifo_full(fifo_full), .busy(busy_a[2]),
    .conv_complete(cc_a[2]), .overflow(ovf_a[2]));

  // ADC model: first bit after CS falls, next bit on each SCLK fall.
  always @(negedge cs_a[0]) bit_idx = 15;
  always @(negedge sclk_a[0]) begin
    if (!cs_a[0] && bit_idx >= 0) begin
      din0 = word0[bit_idx];
      din1 = word1[bit_idx];
      din2 = word2[bit_idx];
      bit_idx = bit_idx - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: SCLK edge timing, CS quiet gaps, write strobes, scoreboard pops.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sclk_a[i] && !sclk_prev[i]) begin
        rise_n[i]++;
        if (rise_n[i] == 1) rise0[i] = cyc;
        else if (rise_n[i] == 2) rise1[i] = cyc;
      end
      sclk_prev[i] = sclk_a[i];
      if (cc_a[i]) conv_cyc[i] = cyc;
    end
    if (cs_a[0]) cs_run++;
    else begin
      if (cs_run != 0) last_cs_run = cs_run;
      cs_run = 0;
    end
    if (wr_a[0]) wr_pulses++;
    if (cc_a[0]) begin
      check("conv_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("px0_data", 32'(d0_a[0]), 32'(e.p0));
        check("px1_data", 32'(d1_a[0]), 32'(e.p1));
        check("px2_data", 32'(d2_a[0]), 32'(e.p2));
        check("wr_en", 32'(wr_a[0]), 32'(e.wr));
        check("overflow", 32'(ovf_a[0]), 32'(e.ovf));
        check("latency", 32'(cyc - e.start), 32'(1 + 33 * 2));
        check("sclk_rises", 32'(rise_n[0]), 32'd16);
      end
    end
  end

  task automatic do_start(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic ff, input bit accepted);
    exp_t e;
    @(negedge clk);
    if (accepted) begin
      word0 = w0; word1 = w1; word2 = w2;
      e.p0 = w0[11:0]; e.p1 = w1[11:0]; e.p2 = w2[11:0];
      e.wr = !ff;
      e.ovf = ovf_model | ff;
      ovf_model = e.ovf;
      e.start = cyc;
      sb.push_back(e);
      if (!ff) exp_wr++;
      start_cyc = cyc;
      for (int i = 0; i < 3; i++) rise_n[i] = 0;
    end
    fifo_full = ff;
    start_capture = 1'b1;
    @(negedge clk);
    start_capture = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy_a[0] && !busy_a[1] && !busy_a[2]) break;
    end
    if (k == limit) check("idle_timeout", 32'(busy_a[0] | busy_a[1] | busy_a[2]), 32'd0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cs", 32'(cs_a[0]), 32'd1);
    check("rst_sclk", 32'(sclk_a[0]), 32'd1);
    check("rst_wr_en", 32'(wr_a[0]), 32'd0);
    check("rst_conv", 32'(cc_a[0]), 32'd0);
    check("rst_busy", 32'(busy_a[0]), 32'd0);
    check("rst_ovf", 32'(ovf_a[0]), 32'd0);
    check("rst_data", 32'({d2_a[0], d1_a[0], d0_a[0]}), 32'd0);

    // Basic conversion with the reference ADC words.
    do_start(16'h0ABC, 16'h0123, 16'h0FFF, 1'b0, 1'b1);
    check("busy_after_start", 32'(busy_a[0]), 32'd1);
    check("cs_low_after_start", 32'(cs_a[0]), 32'd0);
    wait_idle(400);
    repeat (3) @(negedge clk);
    check("hold_px0", 32'(d0_a[0]), 32'h0ABC);
    check("period_div2", 32'(rise1[0] - rise0[0]), 32'd4);

    // FIFO full during DONE: sample dropped, overflow sticks.
    do_start(16'h0555, 16'h0AAA, 16'h0F0F, 1'b1, 1'b1);
    wait_idle(400);
    fifo_full = 1'b0;
    check("ovf_sticky_idle", 32'(ovf_a[0]), 32'd1);

    // Second start while busy is ignored; next start after idle runs.
    do_start(16'h0321, 16'h0654, 16'h0987, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    do_start(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    wait_idle(400);
    do_start(16'hF5A5, 16'h0001, 16'h0800, 1'b0, 1'b1);
    check("cs_quiet_gap", 32'(last_cs_run >= 4), 32'd1);
    wait_idle(400);

    // Reset at the 8th SCLK rising edge aborts the conversion.
    do_start(16'h0111, 16'h0222, 16'h0333, 1'b0, 1'b1);
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (rise_n[0] >= 8) break;
    end
    check("rise8_reached", 32'(rise_n[0]), 32'd8);
    reset = 1'b1;
    #1;
    check("midrst_cs", 32'(cs_a[0]), 32'd1);
    check("midrst_sclk", 32'(sclk_a[0]), 32'd1);
    check("midrst_data", 32'({d2_a[0], d1_a[0], d0_a[0]}), 32'd0);
    check("midrst_busy", 32'(busy_a[0]), 32'd0);
    check("midrst_ovf", 32'(ovf_a[0]), 32'd0);
    sb.delete();
    exp_wr--;
    ovf_model = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("no_wr_after_rst", 32'(wr_pulses), 32'(exp_wr));

    // Timing across CLK_DIV = 2, 1, 5.
    do_start(16'h0FED, 16'h0CBA, 16'h0987, 1'b0, 1'b1);
    wait_idle(600);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("latency_div%0d", DIVS[i]), 32'(conv_cyc[i] - start_cyc), 32'(1 + 33 * DIVS[i]));
      check($sformatf("period_div%0d", DIVS[i]), 32'(rise1[i] - rise0[i]), 32'(2 * DIVS[i]));
      check($sformatf("rises_div%0d", DIVS[i]), 32'(rise_n[i]), 32'd16);
    end
    check("div5_px0", 32'(d0_a[2]), 32'h0FFF);
    check("div5_px1", 32'(d1_a[2]), 32'h0000);
    check("div1_px2", 32'(d2_a[1]), 32'h0FFF);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("wr_pulse_count", 32'(wr_pulses), 32'(exp_wr));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
